// File: rtl/ahb_ram_ctrl.sv
// ahb_ram_ctrl: AHB-Lite slave turning address/data phases into single-cycle RAM commands,
// with one read wait state and a two-cycle ERROR response for illegal transfers.
module ahb_ram_ctrl #(
    parameter int MEM_BYTES = 64,
    parameter int ADDR_W    = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hsel,
    input  logic [1:0]  htrans,
    input  logic [31:0] haddr,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic        hsigned,
    input  logic        hready,
    input  logic [31:0] hwdata,
    output logic [31:0] hrdata,
    output logic        hreadyout,
    output logic        hresp,
    output logic        sel_1,
    output logic        wr_en_ram,
    output logic        rd_en_ram,
    output logic [31:0] wr_data,
    output logic [31:0] address_ram,
    output logic [2:0]  hsize_ram,
    output logic        is_signed,
    input  logic [31:0] ram_rd_data
);
    typedef enum logic [2:0] {IDLE, WR, RD_REQ, RD_DATA, ERR1, ERR2} state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        size_q;
    logic              signed_q;
    logic              accept;
    logic              legal;
    logic              aligned;

    // RD_REQ and ERR1 hold hreadyout low, so no address phase can complete there
    assign accept  = !(state == RD_REQ || state == ERR1) && hsel && htrans >= 2'b10 && hready;
    assign aligned = hsize == 3'b001 ? !haddr[0] : hsize == 3'b010 ? haddr[1:0] == 2'b00 : 1'b1;
    assign legal   = hsize <= 3'b010 && aligned && haddr < 32'(MEM_BYTES);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            addr_q   <= '0;
            size_q   <= '0;
            signed_q <= 1'b0;
        end else begin
            if (accept && legal) begin
                addr_q   <= haddr[ADDR_W-1:0];
                size_q   <= hsize;
                signed_q <= hsigned;
            end
            state <= state == RD_REQ ? RD_DATA :
                     state == ERR1   ? ERR2    :
                     !accept         ? IDLE    :
                     !legal          ? ERR1    :
                     hwrite          ? WR      : RD_REQ;
        end
    end

    // reset gates everything combinationally so a reset cycle never issues a RAM command
    assign sel_1       = !reset && (state == WR || state == RD_REQ);
    assign wr_en_ram   = !reset && state == WR;
    assign rd_en_ram   = !reset && state == RD_REQ;
    assign hreadyout   = reset || !(state == RD_REQ || state == ERR1);
    assign hresp       = !reset && (state == ERR1 || state == ERR2);
    assign hrdata      = (!reset && state == RD_DATA) ? ram_rd_data : '0;
    assign wr_data     = hwdata;
    assign address_ram = reset ? '0 : {{(32-ADDR_W){1'b0}}, addr_q};
    assign hsize_ram   = reset ? '0 : size_q;
    assign is_signed   = !reset && signed_q;
endmodule

// File: tb/tb_ahb_ram_ctrl.sv
// tb_ahb_ram_ctrl: AHB master driver plus RAM stub; transaction-level byte-array reference
// feeds a scoreboard queue that an independent bus monitor drains.
module tb_ahb_ram_ctrl;
    logic        clk = 0;
    logic        reset = 1;
    logic        hsel = 0;
    logic [1:0]  htrans = 0;
    logic [31:0] haddr = 0;
    logic        hwrite = 0;
    logic [2:0]  hsize = 0;
    logic        hsigned = 0;
    logic [31:0] hwdata = 0;
    logic [31:0] hrdata;
    logic        hreadyout;
    logic        hresp;
    logic        sel_1;
    logic        wr_en_ram;
    logic        rd_en_ram;
    logic [31:0] wr_data;
    logic [31:0] address_ram;
    logic [2:0]  hsize_ram;
    logic        is_signed;
    logic [31:0] ram_rd_data = 0;

    ahb_ram_ctrl #(.MEM_BYTES(64), .ADDR_W(6)) dut (
        .clk(clk), .reset(reset), .hsel(hsel), .htrans(htrans), .haddr(haddr),
        .hwrite(hwrite), .hsize(hsize), .hsigned(hsigned), .hready(hreadyout),
        .hwdata(hwdata), .hrdata(hrdata), .hreadyout(hreadyout), .hresp(hresp),
        .sel_1(sel_1), .wr_en_ram(wr_en_ram), .rd_en_ram(rd_en_ram), .wr_data(wr_data),
        .address_ram(address_ram), .hsize_ram(hsize_ram), .is_signed(is_signed),
        .ram_rd_data(ram_rd_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        err;
        logic        rd;
        logic        wr;
        logic [31:0] data;
        logic [31:0] addr;
    } exp_t;

    exp_t        sbq[$];
    logic [7:0]  ram [64];
    logic [7:0]  mem_ref [64];
    logic [31:0] pend_wdata = 0;
    int          n_chk = 0;
    int          n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // little-endian load of 1/2/4 bytes with optional sign extension
    function automatic logic [31:0] load(input logic [7:0] m [64], input logic [5:0] a,
                                         input logic [2:0] sz, input logic sg);
        logic [31:0] v = 0;
        for (int i = 0; i < 4; i++) if (i < (1 << sz)) v[8*i +: 8] = m[6'(a + i)];
        if (sg && sz == 0) v = {{24{v[7]}}, v[7:0]};
        if (sg && sz == 1) v = {{16{v[15]}}, v[15:0]};
        return v;
    endfunction

    // RAM stub: registered read data, writes land on the command edge
    always @(posedge clk) begin
        if (sel_1 && wr_en_ram)
            for (int i = 0; i < 4; i++)
                if (i < (1 << hsize_ram[1:0])) ram[6'(address_ram[5:0] + i)] <= wr_data[8*i +: 8];
        if (sel_1 && rd_en_ram) ram_rd_data <= load(ram, address_ram[5:0], hsize_ram, is_signed);
    end

    task automatic step();
        logic acc;
        acc = hsel && htrans[1] && hreadyout && !reset;
        @(posedge clk);
        #1;
        if (acc) hwdata = pend_wdata;
        hsel = 0;
        htrans = 0;
    endtask

    task automatic issue(input logic sel, input logic [1:0] tr, input logic [31:0] a, input logic w,
                         input logic [2:0] sz, input logic sg, input logic [31:0] wd);
        int g = 0;
        while (!hreadyout && g < 20) begin
            step();
            g++;
        end
        chk("ready_timeout", hreadyout, 1);
        hsel = sel; htrans = tr; haddr = a; hwrite = w; hsize = sz; hsigned = sg; pend_wdata = wd;
        if (sel && tr[1]) begin
            exp_t e;
            e.err = sz > 2 || a >= 64 || (a % (32'd1 << sz)) != 0;
            e.wr = w;
            e.rd = !w;
            e.addr = a;
            e.data = 0;
            if (!e.err && w)
                for (int i = 0; i < (1 << sz); i++) mem_ref[a + i] = wd[8*i +: 8];
            if (!e.err && !w) e.data = load(mem_ref, a[5:0], sz, sg);
            sbq.push_back(e);
        end
        step();
    endtask

    logic dph = 0;
    int   waits = 0;
    int   cmds = 0;

    // bus monitor: follows each data phase to completion and checks it against the queue head
    always @(negedge clk) begin
        if (reset) begin
            chk("rst_hreadyout", hreadyout, 1);
            chk("rst_hresp", hresp, 0);
            chk("rst_hrdata", hrdata, 0);
            chk("rst_enables", {sel_1, wr_en_ram, rd_en_ram}, 0);
            sbq.delete();
            dph = 0;
        end else begin
            chk("en_exclusive", wr_en_ram && rd_en_ram, 0);
            chk("en_needs_sel", (wr_en_ram || rd_en_ram) && !sel_1, 0);
            if (!dph) chk("idle_no_cmd", {sel_1, wr_en_ram, rd_en_ram}, 0);
            else begin
                chk("sb_nonempty", sbq.size() != 0, 1);
                if (sbq.size() != 0) begin
                    exp_t e;
                    e = sbq[0];
                    if (wr_en_ram || rd_en_ram) begin
                        cmds++;
                        chk("err_no_cmd", e.err, 0);
                        chk("cmd_addr", address_ram, e.addr);
                        chk("cmd_dir", wr_en_ram, e.wr);
                    end
                    if (hreadyout) begin
                        chk("waits", waits, (e.err || e.rd) ? 1 : 0);
                        chk("cmd_count", cmds, e.err ? 0 : 1);
                        chk("hresp", hresp, e.err);
                        chk("hrdata", hrdata, (e.rd && !e.err) ? e.data : 0);
                        void'(sbq.pop_front());
                        dph = 0;
                    end else begin
                        waits++;
                        chk("wait_hresp", hresp, e.err);
                        chk("wait_hrdata", hrdata, 0);
                        chk("wait_bound", waits <= 2, 1);
                    end
                end
            end
            if (hsel && htrans[1] && hreadyout) begin
                dph = 1;
                waits = 0;
                cmds = 0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        reset = 0;
        for (int i = 0; i < 16; i++) issue(1, 2'b10, 32'(4 * i), 1, 3'b010, 0, $urandom);
        // directed: word write/read, signed/unsigned byte, illegal transfers
        issue(1, 2'b10, 32'h08, 1, 3'b010, 0, 32'h11223344);
        step();
        issue(1, 2'b10, 32'h08, 0, 3'b010, 0, 0);
        issue(1, 2'b10, 32'h00, 1, 3'b000, 0, 32'h000000AA);
        issue(1, 2'b10, 32'h00, 0, 3'b000, 1, 0);
        issue(1, 2'b10, 32'h00, 0, 3'b000, 0, 0);
        issue(1, 2'b10, 32'h01, 0, 3'b001, 0, 0);
        issue(1, 2'b10, 32'h40, 1, 3'b010, 0, 32'hDEADBEEF);
        issue(1, 2'b11, 32'h00, 0, 3'b011, 0, 0);
        issue(1, 2'b10, 32'h10, 1, 3'b010, 0, 32'hCAFEF00D);
        chk("wr_no_bubble", hreadyout, 1);
        issue(1, 2'b11, 32'h10, 0, 3'b010, 0, 0);
        // reset during the read wait state drops the transfer
        issue(1, 2'b10, 32'h08, 0, 3'b010, 0, 0);
        chk("in_rd_req", {hreadyout, rd_en_ram}, 2'b01);
        reset = 1;
        @(posedge clk);
        #1;
        reset = 0;
        chk("post_rst_ready", hreadyout, 1);
        chk("post_rst_hrdata", hrdata, 0);
        chk("post_rst_cmd", {sel_1, wr_en_ram, rd_en_ram}, 0);
        step();
        chk("post_rst_cmd2", {sel_1, wr_en_ram, rd_en_ram}, 0);
        for (int k = 0; k < 400; k++) begin
            logic [31:0] a;
            logic [2:0]  sz;
            a = $urandom_range(0, 71);
            sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 1);
            issue($urandom_range(0, 9) != 0, 2'($urandom_range(0, 3)), a, 1'($urandom), sz,
                  1'($urandom), $urandom);
            if ($urandom_range(0, 4) == 0) step();
        end
        repeat (4) step();
        chk("drain", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
